// File: rtl/cache_ctrl_wt_if.sv
// Request, response, memory-side and statistics signals of the write-through L1 cache controller.
// master: the core/memory environment (drives requests, mem_ack/mem_rdata, flush, report).
// slave: the cache controller (drives req_ready, responses, memory requests, statistics).
interface cache_ctrl_wt_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  flush;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_hit;
  logic                  mem_req;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;
  logic                  report;
  logic                  stat_valid;
  logic [31:0]           stat_hits;
  logic [31:0]           stat_misses;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, flush, mem_rdata, mem_ack, report,
    input  req_ready, resp_valid, resp_rdata, resp_hit, mem_req, mem_write, mem_addr,
           mem_wdata, stat_valid, stat_hits, stat_misses
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, flush, mem_rdata, mem_ack, report,
    output req_ready, resp_valid, resp_rdata, resp_hit, mem_req, mem_write, mem_addr,
           mem_wdata, stat_valid, stat_hits, stat_misses
  );
endinterface

// File: rtl/cache_ctrl_wt.sv
// Direct-mapped write-through, no-write-allocate L1 data-cache controller, one word per line.
// Latency: load hit responds 2 cycles after acceptance; miss/store raises mem_req at cycle 2, responds 1 cycle after mem_ack.
// Backpressure: req_ready only in IDLE with flush low; single outstanding request; response has no backpressure.
//
// Ports: clk, rst (async active-low), bus (cache_ctrl_wt_if.slave): core request/response,
//        flush, memory-side request/ack, statistics report/snapshot.
// Optional feature: define CACHE_STATS_EN to build saturating hit/miss counters with snapshot reporting.
module cache_ctrl_wt #(
  parameter int CORE       = 0,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LINES      = 16
) (
  input  logic           clk,
  input  logic           rst,
  cache_ctrl_wt_if.slave bus
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MEM    = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  hit_q, hit_d;
  logic [LINES-1:0]      valid_q, valid_d;

  // Tag and data storage carry no reset; the valid bits alone define contents.
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES];

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  lookup_hit;
  logic                  line_we;
  logic [DATA_WIDTH-1:0] line_wdata;
  logic                  req_ready;

  assign idx        = addr_q[IDX_W-1:0];
  assign tag        = addr_q[ADDR_WIDTH-1:IDX_W];
  assign lookup_hit = valid_q[idx] && (tag_mem[idx] == tag);

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    hit_d      = hit_q;
    valid_d    = valid_q;
    line_we    = 1'b0;
    line_wdata = wdata_q;
    req_ready  = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = !bus.flush;
        if (bus.flush) begin
          // Flush wins over a request presented in the same cycle.
          valid_d = '0;
        end else if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        hit_d = lookup_hit;
        if (!write_q && lookup_hit) begin
          rdata_d = data_mem[idx];
          state_d = RESP;
        end else begin
          // Store hit refreshes the line now; store miss leaves it alone.
          line_we = write_q && lookup_hit;
          rdata_d = '0;
          state_d = MEM;
        end
      end

      MEM: begin
        if (bus.mem_ack) begin
          if (!write_q) begin
            line_we      = 1'b1;
            line_wdata   = bus.mem_rdata;
            valid_d[idx] = 1'b1;
            rdata_d      = bus.mem_rdata;
            hit_d        = 1'b0;
          end
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= line_wdata;
    end
  end

  // Outputs decode straight from state_q so reset drops them without a clock edge.
  logic resp_valid;
  logic mem_req;

  assign resp_valid     = (state_q == RESP);
  assign mem_req        = (state_q == MEM);
  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = resp_valid ? rdata_q : '0;
  assign bus.resp_hit   = resp_valid && hit_q;
  assign bus.mem_req    = mem_req;
  assign bus.mem_write  = mem_req && write_q;
  assign bus.mem_addr   = mem_req ? addr_q : '0;
  assign bus.mem_wdata  = (mem_req && write_q) ? wdata_q : '0;

`ifdef CACHE_STATS_EN
  logic [31:0] hits_q, misses_q;
  logic [31:0] snap_hits_q, snap_misses_q;
  logic        stat_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits_q        <= '0;
      misses_q      <= '0;
      snap_hits_q   <= '0;
      snap_misses_q <= '0;
      stat_valid_q  <= 1'b0;
    end else begin
      if (state_q == LOOKUP) begin
        if (lookup_hit) begin
          if (hits_q != 32'hFFFF_FFFF) hits_q <= hits_q + 32'd1;
        end else begin
          if (misses_q != 32'hFFFF_FFFF) misses_q <= misses_q + 32'd1;
        end
      end
      // Snapshot takes the pre-increment values, so a same-cycle event is excluded.
      if (bus.report) begin
        snap_hits_q   <= hits_q;
        snap_misses_q <= misses_q;
      end
      stat_valid_q <= bus.report;
    end
  end

  assign bus.stat_valid  = stat_valid_q;
  assign bus.stat_hits   = snap_hits_q;
  assign bus.stat_misses = snap_misses_q;
`else
  assign bus.stat_valid  = 1'b0;
  assign bus.stat_hits   = '0;
  assign bus.stat_misses = '0;

  logic unused_report;
  assign unused_report = bus.report;
`endif

  // CORE only labels this instance's statistics in a multi-core system; no logic depends on it.
  logic unused_core;
  assign unused_core = (CORE < 0);

endmodule

// File: tb/tb_cache_ctrl_wt.sv
// Randomized scoreboard bench for cache_ctrl_wt: driver + memory responder + response/stat monitor.
module tb_cache_ctrl_wt;
  localparam int LINES = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   ecnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  cache_ctrl_wt_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  cache_ctrl_wt #(.CORE(0), .DATA_WIDTH(32), .ADDR_WIDTH(8), .LINES(LINES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {logic [31:0] rdata; logic hit; logic mem; int acc;} rexp_t;
  typedef struct {logic w; logic [7:0] a; logic [31:0] d; int acc;} mexp_t;
  typedef struct {int hits; int misses; int rep;} sexp_t;

  rexp_t sb_q[$];
  mexp_t mem_q[$];
  sexp_t st_q[$];

  // Reference model: line slot holds the full word address it caches.
  logic        rv [LINES];
  logic [7:0]  ra [LINES];
  logic [31:0] rd [LINES];
  logic [31:0] rmem [256];
  logic [31:0] mem [256];
  int m_hits = 0, m_misses = 0;

  int  fixed_delay = -1;
  bit  hold_ack = 0;
  bit  inject_ack = 0;
  int  ack_e = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out or unexpected event (t=%0t)", name, $time);
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) rv[i] = 1'b0;
  endtask

  task automatic model_req(input logic w, input logic [7:0] a, input logic [31:0] d, input int acc);
    int    li;
    bit    hit;
    rexp_t e;
    li  = a % LINES;
    hit = rv[li] && (ra[li] == a);
    e.acc = acc;
    e.hit = hit;
    if (hit) m_hits++; else m_misses++;
    if (!w) begin
      if (hit) begin
        e.rdata = rd[li];
        e.mem   = 1'b0;
      end else begin
        e.rdata = rmem[a];
        e.mem   = 1'b1;
        rv[li] = 1'b1; ra[li] = a; rd[li] = rmem[a];
        mem_q.push_back('{1'b0, a, 32'h0, acc});
      end
    end else begin
      e.rdata = 32'h0;
      e.mem   = 1'b1;
      if (hit) rd[li] = d;
      rmem[a] = d;
      mem_q.push_back('{1'b1, a, d, acc});
    end
    sb_q.push_back(e);
  endtask

  // Called just after a rising edge; returns with inputs updated just after a later rising edge.
  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d, output int acc);
    bit got;
    got = 0;
    acc = -1;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        got = 1;
        acc = ecnt;
        model_req(w, a, d, acc);
      end
    end
    if (!got) fail_now("req_accept");
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && mem_q.size() == 0 && !bus.mem_req) done = 1;
    end
    if (!done) fail_now("wait_idle");
    @(posedge clk); #1;
  endtask

  task automatic flush_pulse();
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_ready_low", bus.req_ready, 1'b0);
    model_clear();
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  task automatic do_report();
`ifdef CACHE_STATS_EN
    st_q.push_back('{m_hits, m_misses, ecnt});
`endif
    bus.report = 1'b1;
    @(posedge clk); #1;
    bus.report = 1'b0;
`ifdef CACHE_STATS_EN
    begin
      bit done;
      done = 0;
      for (int i = 0; i < 10 && !done; i++) begin
        @(negedge clk);
        if (st_q.size() == 0) done = 1;
      end
      if (!done) fail_now("stat_valid_wait");
    end
`else
    @(negedge clk);
    chk("stat_valid_off", bus.stat_valid, 1'b0);
    chk("stat_hits_off", bus.stat_hits, 32'h0);
    chk("stat_misses_off", bus.stat_misses, 32'h0);
`endif
    @(posedge clk); #1;
  endtask

  // Memory responder: checks each new memory request against the expected queue and acks after a delay.
  initial begin : responder
    bit    busy;
    int    cnt;
    mexp_t cur;
    busy = 0;
    cnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (!rst) begin
        busy = 0;
      end else if (bus.mem_req) begin
        if (!busy) begin
          if (mem_q.size() == 0) begin
            fail_now("unexpected_mem_req");
            cur = '{bus.mem_write, bus.mem_addr, bus.mem_wdata, ecnt - 2};
          end else begin
            cur = mem_q.pop_front();
          end
          chk("mem_req_cycle", ecnt, cur.acc + 2);
          busy = 1;
          cnt = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 4);
        end
        chk("mem_addr", bus.mem_addr, cur.a);
        chk("mem_write", bus.mem_write, cur.w);
        if (cur.w) chk("mem_wdata", bus.mem_wdata, cur.d);
        if (!hold_ack) begin
          if (cnt == 0) begin
            bus.mem_ack = 1'b1;
            if (cur.w) mem[cur.a] = cur.d;
            else bus.mem_rdata = mem[cur.a];
            ack_e = ecnt;
            busy = 0;
          end else begin
            cnt--;
          end
        end
      end else if (inject_ack) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = $urandom;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a response or statistics snapshot.
  always @(negedge clk) begin
    if (rst && bus.resp_valid) begin
      if (sb_q.size() == 0) begin
        fail_now("unexpected_resp");
      end else begin
        rexp_t e;
        e = sb_q.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_hit", bus.resp_hit, e.hit);
        if (e.mem) chk("resp_lat_mem", ecnt, ack_e + 1);
        else       chk("resp_lat_hit", ecnt, e.acc + 2);
      end
    end
    if (rst && bus.stat_valid) begin
      if (st_q.size() == 0) begin
        fail_now("unexpected_stat_valid");
      end else begin
        sexp_t s;
        s = st_q.pop_front();
        chk("stat_hits", bus.stat_hits, s.hits);
        chk("stat_misses", bus.stat_misses, s.misses);
        chk("stat_valid_cycle", ecnt, s.rep + 1);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int acc, a1, a2, a3;
    bit got, saw;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h0;
    bus.req_wdata = 32'h0;
    bus.flush     = 1'b0;
    bus.report    = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = $urandom;
      rmem[i] = mem[i];
    end
    mem[5] = 32'hDEADBEEF;
    rmem[5] = 32'hDEADBEEF;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_req", bus.mem_req, 1'b0);
    chk("reset_resp_valid", bus.resp_valid, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", bus.req_ready, 1'b1);
    chk("reset_stat_valid", bus.stat_valid, 1'b0);
    chk("reset_stat_hits", bus.stat_hits, 32'h0);
    chk("reset_resp_rdata", bus.resp_rdata, 32'h0);
    @(posedge clk); #1;

    // Miss with ack 3 cycles after mem_req, then hit, conflict replacement, re-miss, hit.
    fixed_delay = 3;
    issue(1'b0, 8'h05, 32'h0, acc); wait_idle();
    issue(1'b0, 8'h05, 32'h0, acc); wait_idle();
    fixed_delay = -1;
    issue(1'b0, 8'h15, 32'h0, acc); wait_idle();
    issue(1'b0, 8'h05, 32'h0, acc); wait_idle();
    issue(1'b0, 8'h05, 32'h0, acc); wait_idle();
    do_report();

    // Back-to-back hits: one acceptance every 3 cycles.
    issue(1'b0, 8'h05, 32'h0, a1);
    issue(1'b0, 8'h05, 32'h0, a2);
    issue(1'b0, 8'h05, 32'h0, a3);
    chk("hit_throughput_1", a2 - a1, 3);
    chk("hit_throughput_2", a3 - a2, 3);
    wait_idle();

    // Store hit, load back, store miss without allocate.
    issue(1'b1, 8'h05, 32'h12345678, acc); wait_idle();
    issue(1'b0, 8'h05, 32'h0, acc); wait_idle();
    issue(1'b1, 8'h07, 32'hCAFEF00D, acc); wait_idle();
    issue(1'b0, 8'h07, 32'h0, acc); wait_idle();

    // Flush and request in the same idle cycle: flush wins.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h05;
    flush_pulse();
    bus.req_valid = 1'b0;
    issue(1'b0, 8'h05, 32'h0, acc); wait_idle();
    do_report();

    // Reset while waiting in MEM.
    flush_pulse();
    hold_ack = 1;
    issue(1'b0, 8'h40, 32'h0, acc);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.mem_req) got = 1;
    end
    if (!got) fail_now("mem_req_before_reset");
    #2 rst = 1'b0;
    #1;
    chk("async_rst_mem_req", bus.mem_req, 1'b0);
    chk("async_rst_resp_valid", bus.resp_valid, 1'b0);
    sb_q.delete();
    mem_q.delete();
    model_clear();
    m_hits = 0;
    m_misses = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    hold_ack = 0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", bus.req_ready, 1'b1);
    inject_ack = 1;
    saw = 0;
    repeat (4) begin
      @(negedge clk);
      saw = saw | bus.resp_valid;
    end
    inject_ack = 0;
    chk("late_ack_no_resp", saw, 1'b0);
    @(posedge clk); #1;
    issue(1'b0, 8'h40, 32'h0, acc); wait_idle();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [7:0] ad;
      r = $urandom_range(0, 29);
      ad = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 47));
      if (r == 0) begin
        wait_idle();
        flush_pulse();
      end else if (r == 1) begin
        wait_idle();
        do_report();
      end else begin
        issue(($urandom_range(0, 2) == 0), ad, $urandom, acc);
        if ($urandom_range(0, 2) == 0) begin
          @(posedge clk); #1;
        end
      end
    end
    wait_idle();
    do_report();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
